transpose_buffer_writer: RTL and testbench

- Write side of the interpolation transposed buffer.
- Accepts 11 horizontal rows of 4 9-bit samples (one row per handshake) and stores them column-wise in four 99-bit column registers.
- Then sequences the column-select code 1..4 to the column-selection mux, so the vertical filter stage reads one full column per cycle.
- Sits between the horizontal interpolation output and the vertical filter input.

---
 rtl/transpose_buffer_writer.sv | 90 +++++++++
 tb/tb_transpose_buffer_writer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/transpose_buffer_writer.sv
// transpose_buffer_writer: write side of the interpolation transposed buffer.
// Collects ROWS horizontal rows of COLS samples into COLS column registers,
// then presents select codes 1..COLS so the vertical stage reads one column per cycle.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             synchronous abort back to FILL (column contents kept)
//   row_valid/ready   upstream row handshake, row_in sample c at [9c+8:9c]
//   col_ready         downstream accepts the presented column
//   column_1..4       column registers, row r at [9r+8:9r]
//   select            column code 1..4 while presenting, 0 otherwise
//   col_valid         select holds a valid code
//   block_done        one-cycle pulse after the last column is accepted
module transpose_buffer_writer #(
    parameter int SAMPLE_W = 9,
    parameter int ROWS     = 11,
    parameter int COLS     = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       row_valid,
    input  logic [COLS*SAMPLE_W-1:0]   row_in,
    output logic                       row_ready,
    input  logic                       col_ready,
    output logic [ROWS*SAMPLE_W-1:0]   column_1,
    output logic [ROWS*SAMPLE_W-1:0]   column_2,
    output logic [ROWS*SAMPLE_W-1:0]   column_3,
    output logic [ROWS*SAMPLE_W-1:0]   column_4,
    output logic [2:0]                 select,
    output logic                       col_valid,
    output logic                       block_done
);
    localparam int RW = $clog2(ROWS);
    localparam logic [0:0] FILL = 1'b0;
    localparam logic [0:0] READ = 1'b1;
    logic [0:0]               state;
    logic [RW-1:0]            row_cnt;
    logic [ROWS*SAMPLE_W-1:0] col [COLS];
    logic                     row_acc;
    assign row_ready = state == FILL;
    assign col_valid = state == READ;
    // a row presented together with flush is dropped
    assign row_acc   = row_valid && state == FILL && !flush;
    assign column_1  = col[0];
    assign column_2  = col[1];
    assign column_3  = col[2];
    assign column_4  = col[3];
    // select doubles as the column counter: it is always counter+1 in READ
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FILL;
            row_cnt    <= '0;
            select     <= '0;
            block_done <= 1'b0;
        end else begin
            block_done <= 1'b0;
            if (flush) begin
                state   <= FILL;
                row_cnt <= '0;
                select  <= '0;
            end else if (state == FILL) begin
                if (row_valid) begin
                    if (row_cnt == RW'(ROWS - 1)) begin
                        row_cnt <= '0;
                        state   <= READ;
                        select  <= 3'd1;
                    end else begin
                        row_cnt <= row_cnt + 1'b1;
                    end
                end
            end else if (col_ready) begin
                if (select == 3'(COLS)) begin
                    state      <= FILL;
                    select     <= '0;
                    block_done <= 1'b1;
                end else begin
                    select <= select + 3'd1;
                end
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < COLS; c++) col[c] <= '0;
        end else if (row_acc) begin
            for (int c = 0; c < COLS; c++)
                col[c][row_cnt*SAMPLE_W +: SAMPLE_W] <= row_in[c*SAMPLE_W +: SAMPLE_W];
        end
    end
endmodule

// File: tb/tb_transpose_buffer_writer.sv
// tb_transpose_buffer_writer: directed and randomized checks of transpose_buffer_writer against a sample-array model.
module tb_transpose_buffer_writer;
    logic        clk = 0, rst_n = 0, flush = 0, row_valid = 0, col_ready = 0;
    logic [35:0] row_in = '0;
    logic        row_ready, col_valid, block_done;
    logic [98:0] column_1, column_2, column_3, column_4;
    logic [2:0]  select;
    int total = 0, bad = 0, cyc = 0;
    bit cmp_en = 0;

    transpose_buffer_writer dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .row_valid(row_valid),
        .row_in(row_in), .row_ready(row_ready), .col_ready(col_ready),
        .column_1(column_1), .column_2(column_2), .column_3(column_3),
        .column_4(column_4), .select(select), .col_valid(col_valid),
        .block_done(block_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // model: a 4x11 sample array plus "filling or reading" and two indices
    logic [8:0] m_mem [4][11];
    bit m_fill = 1, m_done = 0;
    int m_row = 0, m_col = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_fill <= 1;
            m_row  <= 0;
            m_col  <= 0;
            m_done <= 0;
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 11; r++) m_mem[c][r] <= '0;
        end else begin
            m_done <= 0;
            if (flush) begin
                m_fill <= 1;
                m_row  <= 0;
                m_col  <= 0;
            end else if (m_fill) begin
                if (row_valid) begin
                    for (int c = 0; c < 4; c++) m_mem[c][m_row] <= row_in[9*c +: 9];
                    m_row <= (m_row == 10) ? 0 : m_row + 1;
                    if (m_row == 10) m_fill <= 0;
                end
            end else if (col_ready) begin
                m_col <= (m_col == 3) ? 0 : m_col + 1;
                if (m_col == 3) begin
                    m_fill <= 1;
                    m_done <= 1;
                end
            end
        end
    end

    function automatic logic [98:0] m_column(int c);
        logic [98:0] v;
        for (int r = 0; r < 11; r++) v[9*r +: 9] = m_mem[c][r];
        return v;
    endfunction

    function automatic logic [98:0] dut_column(int c);
        return c == 0 ? column_1 : c == 1 ? column_2 : c == 2 ? column_3 : column_4;
    endfunction

    task automatic chk(string n, logic [98:0] a, logic [98:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en && rst_n) begin
            chk("row_ready", 99'(row_ready), 99'(m_fill));
            chk("col_valid", 99'(col_valid), 99'(!m_fill));
            chk("select", 99'(select), m_fill ? 99'(0) : 99'(m_col + 1));
            chk("block_done", 99'(block_done), 99'(m_done));
            for (int c = 0; c < 4; c++) chk($sformatf("column_%0d", c + 1), dut_column(c), m_column(c));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_row(input logic [35:0] d);
        bit acc;
        int n;
        row_valid = 1;
        row_in = d;
        n = 0;
        forever begin
            acc = row_ready && !flush;
            tick();
            if (acc) break;
            n++;
            if (n > 50) begin
                total++;
                bad++;
                $display("FAIL row_timeout: row never accepted");
                break;
            end
        end
        row_valid = 0;
    endtask

    function automatic logic [35:0] rnd_row();
        return 36'({$urandom(), $urandom()});
    endfunction

    initial begin
        logic [98:0] held;
        logic [35:0] first;
        int last_done, np;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        chk("rst_column_1", column_1, 0);
        chk("rst_column_4", column_4, 0);
        chk("rst_select", 99'(select), 0);
        chk("rst_col_valid", 99'(col_valid), 0);
        chk("rst_row_ready", 99'(row_ready), 1);
        chk("rst_block_done", 99'(block_done), 0);
        cmp_en = 1;
        // full block, no stalls
        col_ready = 1;
        for (int r = 0; r < 11; r++)
            send_row({9'(16*r + 3), 9'(16*r + 2), 9'(16*r + 1), 9'(16*r)});
        for (int s = 1; s <= 4; s++) begin
            chk("full_select_seq", 99'(select), 99'(s));
            tick();
        end
        chk("full_done", 99'(block_done), 1);
        chk("full_ready", 99'(row_ready), 1);
        chk("full_select_idle", 99'(select), 0);
        chk("full_c1_r0", 99'(column_1[8:0]), 0);
        chk("full_c1_r10", 99'(column_1[98:90]), 160);
        chk("full_c4_r10", 99'(column_4[98:90]), 163);
        tick();
        chk("full_done_once", 99'(block_done), 0);
        // stalls on both sides
        for (int r = 0; r < 11; r++) begin
            if (r != 0) tick();
            send_row(rnd_row());
        end
        chk("stall_sel1", 99'(select), 1);
        tick();
        chk("stall_sel2", 99'(select), 2);
        col_ready = 0;
        held = column_2;
        repeat (3) begin
            tick();
            chk("stall_hold_sel", 99'(select), 2);
            chk("stall_hold_col", column_2, held);
        end
        col_ready = 1;
        tick();
        chk("stall_sel3", 99'(select), 3);
        tick();
        chk("stall_sel4", 99'(select), 4);
        tick();
        chk("stall_done", 99'(block_done), 1);
        // flush mid-fill, then fresh rows 200+r
        for (int r = 0; r < 6; r++) send_row(rnd_row());
        flush = 1;
        tick();
        flush = 0;
        chk("flush_ready", 99'(row_ready), 1);
        chk("flush_select", 99'(select), 0);
        col_ready = 0;
        for (int r = 0; r < 11; r++) begin
            if (r == 5) chk("flush_no_read", 99'(col_valid), 0);
            send_row({4{9'(200 + r)}});
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 11; r++) begin
                held = dut_column(c);
                chk("flush_slot", 99'(held[9*r +: 9]), 99'(200 + r));
            end
        chk("flush_read_sel", 99'(select), 1);
        col_ready = 1;
        repeat (4) tick();
        chk("flush_read_done", 99'(block_done), 1);
        // asynchronous reset during readout
        for (int r = 0; r < 11; r++) send_row(rnd_row());
        tick();
        tick();
        chk("mid_sel3", 99'(select), 3);
        #1 rst_n = 0;
        #1;
        chk("mid_rst_select", 99'(select), 0);
        chk("mid_rst_col_valid", 99'(col_valid), 0);
        chk("mid_rst_column_1", column_1, 0);
        chk("mid_rst_column_3", column_3, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1;
        first = rnd_row();
        send_row(first);
        chk("mid_refill_row0", 99'(column_1[8:0]), 99'(first[8:0]));
        for (int r = 1; r < 11; r++) send_row(rnd_row());
        repeat (4) tick();
        // back-to-back blocks
        row_valid = 1;
        last_done = -1;
        np = 0;
        repeat (80) begin
            row_in = rnd_row();
            tick();
            if (block_done) begin
                np++;
                chk("bb_ready", 99'(row_ready), 1);
                if (last_done >= 0) chk("bb_period", 99'(cyc - last_done), 15);
                last_done = cyc;
            end
        end
        chk("bb_pulses", 99'(np >= 4), 1);
        row_valid = 0;
        repeat (20) tick();
        // randomized traffic with occasional flush
        repeat (3000) begin
            row_valid = 1'($urandom_range(0, 1));
            col_ready = $urandom_range(0, 2) != 0;
            flush = $urandom_range(0, 29) == 0;
            row_in = rnd_row();
            tick();
        end
        flush = 0;
        row_valid = 0;
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
